// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser: FSM state encoding,
// ASCII constants and error codes.
`timescale 1ns/1ps
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SP1     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_SP2     = 3'd3,
    ST_DATA    = 3'd4,
    ST_ISSUE   = 3'd5,
    ST_DISCARD = 3'd6
  } cmd_state_t;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_W  = 8'h57;
  localparam logic [7:0] CH_R  = 8'h52;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SYNTAX  = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  // Fold lowercase ASCII letters onto uppercase; other bytes pass through.
  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? (c & 8'hDF) : c;
  endfunction

endpackage

// File: rtl/uart_hex_decode.sv
// Combinational ASCII hex digit decoder (0-9, A-F, a-f).
`timescale 1ns/1ps
module uart_hex_decode (
  input  logic [7:0] ch,
  output logic [3:0] nibble,
  output logic       is_hex
);

  // Letters map through their low nibble: 'A'/'a' low nibble is 1, plus 9 gives 10.
  always_comb begin
    nibble = 4'h0;
    is_hex = 1'b0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      nibble = ch[3:0];
      is_hex = 1'b1;
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      nibble = ch[3:0] + 4'd9;
      is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses "W addr data<CR>" / "R addr<CR>" text lines from a UART into
// memory commands. Errors are latched in err_code and strobed once per line.
//
// Command handshake: cmd_valid is high from the cycle after the terminating
// CR until the cycle cmd_valid & cmd_ready are both high at a rising edge;
// that edge is the transfer. cmd_write/cmd_addr/cmd_data do not change while
// cmd_valid is high. cmd_ready may be asserted before cmd_valid.
`timescale 1ns/1ps
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int ADDR_W     = 29,
  parameter int MAX_DIGITS = 8
) (
  input  logic              clk_33m,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [31:0]       cmd_data,
  output logic              err_pulse,
  output logic [1:0]        err_code,
  output cmd_state_t        dbg_state
);

  localparam int              CNT_W   = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  cmd_state_t        state, state_n;
  logic [31:0]       acc, acc_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              write_q, write_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [1:0]        err_n;
  logic              pulse_n;
  logic              issue;

  logic [3:0]        nibble;
  logic              is_hex;
  logic [7:0]        ch_up;
  logic [31:0]       acc_shift;
  logic              addr_over;
  logic              full;

  uart_hex_decode u_hex (
    .ch     (rx_byte),
    .nibble (nibble),
    .is_hex (is_hex)
  );

  assign ch_up     = to_upper(rx_byte);
  assign acc_shift = {acc[27:0], nibble};
  // Any accumulator bit at or above ADDR_W means the address does not fit.
  assign addr_over = (acc >> ADDR_W) != 32'd0;
  assign full      = (cnt == CNT_MAX);
  assign cmd_valid = (state == ST_ISSUE);
  assign dbg_state = state;

  // State and datapath registers; outputs only load when a command issues.
  always_ff @(posedge clk_33m or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      err_pulse <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      write_q   <= write_n;
      addr_q    <= addr_n;
      err_pulse <= pulse_n;
      if (err_n != ERR_NONE) err_code <= err_n;
      if (issue) begin
        cmd_write <= write_q;
        cmd_addr  <= addr_n;
        cmd_data  <= write_q ? acc : 32'd0;
      end
    end
  end

  // Next-state decode: one received byte advances the line grammar by one step.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    write_n = write_q;
    addr_n  = addr_q;
    err_n   = ERR_NONE;
    pulse_n = 1'b0;
    issue   = 1'b0;

    if (state == ST_ISSUE && cmd_ready) state_n = ST_IDLE;

    if (rx_valid && rx_byte != CH_LF) begin
      case (state)
        ST_IDLE: begin
          if (ch_up == CH_W) begin
            state_n = ST_SP1;
            write_n = 1'b1;
          end else if (ch_up == CH_R) begin
            state_n = ST_SP1;
            write_n = 1'b0;
          end else if (rx_byte != CH_CR) begin
            state_n = ST_DISCARD;
            err_n   = ERR_SYNTAX;
          end
        end
        ST_SP1: begin
          if (rx_byte == CH_SP) begin
            state_n = ST_ADDR;
            acc_n   = '0;
            cnt_n   = '0;
          end else begin
            state_n = ST_DISCARD;
            err_n   = ERR_SYNTAX;
          end
        end
        ST_ADDR: begin
          if (is_hex) begin
            if (full) begin
              state_n = ST_DISCARD;
              err_n   = ERR_RANGE;
            end else begin
              acc_n = acc_shift;
              cnt_n = cnt + CNT_ONE;
            end
          end else if (cnt != '0 && ((write_q && rx_byte == CH_SP) ||
                                     (!write_q && rx_byte == CH_CR))) begin
            if (addr_over) begin
              state_n = ST_DISCARD;
              err_n   = ERR_RANGE;
            end else begin
              addr_n = acc[ADDR_W-1:0];
              if (write_q) begin
                state_n = ST_SP2;
              end else begin
                state_n = ST_ISSUE;
                issue   = 1'b1;
              end
            end
          end else begin
            state_n = ST_DISCARD;
            err_n   = ERR_SYNTAX;
          end
        end
        ST_SP2: begin
          if (rx_byte != CH_SP) begin
            if (is_hex) begin
              state_n = ST_DATA;
              acc_n   = {28'h0, nibble};
              cnt_n   = CNT_ONE;
            end else begin
              state_n = ST_DISCARD;
              err_n   = ERR_SYNTAX;
            end
          end
        end
        ST_DATA: begin
          if (is_hex) begin
            if (full) begin
              state_n = ST_DISCARD;
              err_n   = ERR_RANGE;
            end else begin
              acc_n = acc_shift;
              cnt_n = cnt + CNT_ONE;
            end
          end else if (rx_byte == CH_CR && cnt != '0) begin
            state_n = ST_ISSUE;
            issue   = 1'b1;
          end else begin
            state_n = ST_DISCARD;
            err_n   = ERR_SYNTAX;
          end
        end
        ST_ISSUE: begin
          // The byte is lost; the pending command is left untouched.
          err_n   = ERR_OVERRUN;
          pulse_n = 1'b1;
        end
        ST_DISCARD: begin
          if (rx_byte == CH_CR) begin
            state_n = ST_IDLE;
            pulse_n = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase

      // An error detected on the CR itself already ends the line.
      if ((err_n == ERR_SYNTAX || err_n == ERR_RANGE) && rx_byte == CH_CR) begin
        state_n = ST_IDLE;
        pulse_n = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser: directed lines plus randomized lines checked
// against a token-level line model and a command scoreboard.
`timescale 1ns/1ps
module tb_uart_cmd_parser;
  import uart_cmd_pkg::*;

  localparam int ADDR_W = 29;
  localparam int MAXD   = 8;
  localparam int CMD_W  = 1 + ADDR_W + 32;
  localparam int K_NONE = 0;
  localparam int K_CMD  = 1;
  localparam int K_ERR  = 2;

  // ---------------- clock / reset ----------------
  logic              clk_33m = 1'b0;
  logic              resetn;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_data;
  logic              err_pulse;
  logic [1:0]        err_code;
  cmd_state_t        dbg_state;

  always #15 clk_33m = ~clk_33m;

  uart_cmd_parser #(.ADDR_W(ADDR_W), .MAX_DIGITS(MAXD)) dut (
    .clk_33m   (clk_33m),
    .resetn    (resetn),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;
  int valid_cnt = 0;
  int xfer_cnt  = 0;
  logic [CMD_W-1:0] exp_q[$];
  logic [7:0] line_q[$];
  logic [7:0] mq[$];
  logic [7:0] junk_tab [8];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk_33m) begin
    if (resetn) begin
      if (err_pulse) pulse_cnt++;
      if (cmd_valid) valid_cnt++;
      if (cmd_valid && cmd_ready) begin
        check_eq("xfer_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check_eq("xfer_cmd", {cmd_write, cmd_addr, cmd_data}, exp_q.pop_front());
        xfer_cnt++;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int hex_val(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  task automatic scan_hex(inout int i, output int n, output logic [63:0] v);
    n = 0;
    v = '0;
    while (i < mq.size() && hex_val(mq[i]) >= 0) begin
      v = (v << 4) | 64'(hex_val(mq[i]));
      n++;
      i++;
    end
  endtask

  // Token-level view of one line: command letter, space, hex field(s), CR.
  task automatic model_line(output int kind, output logic [1:0] code, output logic [CMD_W-1:0] cmd);
    int i, n;
    logic wr;
    logic [63:0] v, addr;
    logic [7:0] c0;
    mq.delete();
    foreach (line_q[k]) if (line_q[k] != CH_LF) mq.push_back(line_q[k]);
    kind = K_ERR;
    code = 2'd1;
    cmd  = '0;
    if (mq.size() == 1) begin kind = K_NONE; code = 2'd0; return; end
    c0 = mq[0] & 8'hDF;
    if (c0 == "W") wr = 1'b1;
    else if (c0 == "R") wr = 1'b0;
    else return;
    if (mq[1] != CH_SP) return;
    i = 2;
    scan_hex(i, n, v);
    if (n > MAXD) begin code = 2'd2; return; end
    if (n == 0) return;
    if (mq[i] != (wr ? CH_SP : CH_CR)) return;
    if (v >= (64'd1 << ADDR_W)) begin code = 2'd2; return; end
    addr = v;
    if (!wr) begin
      kind = K_CMD; code = 2'd0;
      cmd = {1'b0, addr[ADDR_W-1:0], 32'd0};
      return;
    end
    while (i < mq.size() && mq[i] == CH_SP) i++;
    scan_hex(i, n, v);
    if (n > MAXD) begin code = 2'd2; return; end
    if (n == 0) return;
    if (mq[i] != CH_CR) return;
    kind = K_CMD; code = 2'd0;
    cmd = {1'b1, addr[ADDR_W-1:0], v[31:0]};
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_33m); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk_33m); #1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic set_line(input string s, input bit cr, input bit lf);
    line_q.delete();
    for (int i = 0; i < s.len(); i++) line_q.push_back(s[i]);
    if (cr) line_q.push_back(CH_CR);
    if (lf) line_q.push_back(CH_LF);
  endtask

  task automatic push_hex(input int n);
    int d;
    logic [7:0] c;
    repeat (n) begin
      d = $urandom_range(0, 15);
      c = (d < 10) ? 8'(8'h30 + d) : 8'(8'h41 + d - 10);
      if ($urandom_range(0, 1) == 1) c = c | 8'h20;
      line_q.push_back(c);
    end
  endtask

  task automatic gen_line();
    int pos;
    logic wr;
    logic [7:0] c;
    line_q.delete();
    wr = 1'($urandom_range(0, 1));
    c = wr ? 8'h57 : 8'h52;
    if ($urandom_range(0, 1) == 1) c = c | 8'h20;
    line_q.push_back(c);
    line_q.push_back(CH_SP);
    push_hex(($urandom_range(0, 9) == 0) ? 9 : $urandom_range(1, MAXD));
    if (wr) begin
      repeat ($urandom_range(1, 3)) line_q.push_back(CH_SP);
      push_hex(($urandom_range(0, 9) == 0) ? 9 : $urandom_range(1, MAXD));
    end
    line_q.push_back(CH_CR);
    if ($urandom_range(0, 4) == 0) begin
      pos = $urandom_range(0, line_q.size() - 2);
      line_q[pos] = junk_tab[$urandom_range(0, 7)];
    end
    if ($urandom_range(0, 3) == 0) begin
      pos = $urandom_range(0, line_q.size() - 1);
      line_q.insert(pos, CH_LF);
    end
    if ($urandom_range(0, 3) == 0) line_q.push_back(CH_LF);
    if ($urandom_range(0, 24) == 0) begin
      line_q.delete();
      line_q.push_back(CH_CR);
    end
  endtask

  task automatic wait_valid();
    for (int t = 0; t < 20 && !cmd_valid; t++) @(negedge clk_33m);
    check_eq("cmd_valid_seen", cmd_valid, 1);
  endtask

  task automatic wait_xfer(input int x0);
    for (int t = 0; t < 20 && xfer_cnt == x0; t++) @(negedge clk_33m);
    check_eq("xfer_done", xfer_cnt - x0, 1);
  endtask

  // mode 0: ready high early; mode 1: random hold; mode 2: hold 10 cycles.
  task automatic run_line(input int mode, input bit ovr);
    int kind, p0, x0, n_exp;
    logic [1:0] code;
    logic [CMD_W-1:0] cmd;
    model_line(kind, code, cmd);
    p0 = pulse_cnt;
    x0 = xfer_cnt;
    n_exp = (kind == K_ERR) ? 1 : 0;
    cmd_ready = (mode == 0);
    if (kind == K_CMD) exp_q.push_back(cmd);
    foreach (line_q[k]) begin
      send_byte(line_q[k]);
      idle($urandom_range(0, 2));
    end
    if (kind == K_CMD) begin
      if (mode != 0) begin
        wait_valid();
        idle((mode == 2) ? 10 : $urandom_range(0, 6));
        if (ovr) begin
          send_byte(($urandom_range(0, 1) == 1) ? CH_CR : 8'h41);
          @(negedge clk_33m);
          check_eq("ovr_pulse", err_pulse, 1);
          check_eq("ovr_code", err_code, 2'd3);
          check_eq("ovr_valid_kept", cmd_valid, 1);
          n_exp++;
          idle(1);
        end
        cmd_ready = 1'b1;
      end
      wait_xfer(x0);
      idle(1);
    end
    cmd_ready = 1'b0;
    idle(3);
    check_eq("err_pulses", pulse_cnt - p0, n_exp);
    if (kind == K_ERR) check_eq("err_code", err_code, code);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int v0, p0;
    junk_tab = '{8'h47, 8'h78, 8'h57, 8'h72, 8'h20, 8'h30, 8'h66, 8'h5A};
    resetn    = 1'b0;
    rx_valid  = 1'b0;
    rx_byte   = 8'h00;
    cmd_ready = 1'b0;
    idle(3);
    check_eq("rst_valid", cmd_valid, 0);
    check_eq("rst_write", cmd_write, 0);
    check_eq("rst_addr", cmd_addr, 0);
    check_eq("rst_data", cmd_data, 0);
    check_eq("rst_pulse", err_pulse, 0);
    check_eq("rst_code", err_code, 0);
    check_eq("rst_state", dbg_state, ST_IDLE);
    resetn = 1'b1;
    idle(2);

    // Write with ready already high: exactly one valid cycle.
    set_line("W 100 CAFEBABE", 1, 0);
    v0 = valid_cnt;
    run_line(0, 0);
    check_eq("d35_valid_cycles", valid_cnt - v0, 1);

    // Lowercase read with trailing LF, consumer stalls 10 cycles.
    set_line("r 1fffffff", 1, 1);
    v0 = valid_cnt;
    run_line(2, 0);
    check_eq("d36_valid_held", (valid_cnt - v0) >= 11, 1);

    // Address out of range, then bad command letter.
    set_line("R 20000000", 1, 0);
    run_line(1, 0);
    check_eq("d37_range_code", err_code, 2'd2);
    set_line("X 12", 1, 0);
    run_line(1, 0);
    check_eq("d37_syntax_code", err_code, 2'd1);

    // Nine data digits, then a good read.
    set_line("W 1 123456789", 1, 0);
    run_line(1, 0);
    check_eq("d38_range_code", err_code, 2'd2);
    set_line("R 4", 1, 0);
    run_line(1, 0);

    // Overrun while a command is pending; multiple spaces before data.
    set_line("w 2A   dead", 1, 0);
    run_line(1, 1);
    set_line("", 1, 0);
    run_line(0, 0);

    // Randomized lines.
    for (int n = 0; n < 80; n++) begin
      int mode;
      gen_line();
      mode = $urandom_range(0, 1);
      run_line(mode, (mode != 0) && ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a line.
    set_line("W 10 55", 0, 0);
    p0 = pulse_cnt;
    foreach (line_q[k]) send_byte(line_q[k]);
    #5 resetn = 1'b0;
    #2;
    check_eq("d40_valid", cmd_valid, 0);
    check_eq("d40_write", cmd_write, 0);
    check_eq("d40_addr", cmd_addr, 0);
    check_eq("d40_data", cmd_data, 0);
    check_eq("d40_pulse", err_pulse, 0);
    check_eq("d40_code", err_code, 0);
    check_eq("d40_state", dbg_state, ST_IDLE);
    idle(2);
    resetn = 1'b1;
    idle(2);
    check_eq("d40_no_pulse", pulse_cnt - p0, 0);
    set_line("R 0", 1, 0);
    run_line(1, 0);

    // Reset while a command waits for the consumer.
    set_line("R 5", 1, 0);
    cmd_ready = 1'b0;
    foreach (line_q[k]) send_byte(line_q[k]);
    wait_valid();
    p0 = pulse_cnt;
    #5 resetn = 1'b0;
    #2;
    check_eq("mh_valid_cleared", cmd_valid, 0);
    check_eq("mh_addr_cleared", cmd_addr, 0);
    idle(2);
    resetn = 1'b1;
    idle(3);
    check_eq("mh_no_pulse", pulse_cnt - p0, 0);
    check_eq("mh_state", dbg_state, ST_IDLE);
    set_line("W 7 1", 1, 0);
    run_line(1, 0);

    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
